onchip_ram_pipelined: RTL and testbench

//  Parametrised single-port on-chip RAM, Avalon-MM slave s1. Successor of the fixed 32x50000 block.

---
 rtl/onchip_ram_pipelined.sv | 140 ++++++++++++++
 tb/tb_onchip_ram_pipelined.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_pipelined.sv
// Parametrised single-port on-chip RAM, Avalon-MM slave s1.
// Optional clear sweep after reset, 1/2-cycle read pipeline, sticky range error.
module onchip_ram_pipelined #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 16,
  parameter int                DEPTH          = 50000,
  parameter int                READ_LATENCY   = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter                    INIT_FILE      = "ram.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                busy,
  output logic                addr_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_vq;
  logic [DATA_W-1:0] r_dq;
  logic [DATA_W-1:0] r_hold;

  logic              w_en;
  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic              w_inr;
  logic              w_sweep;
  logic              w_rdv;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;
  logic              w_p_v;
  logic [DATA_W-1:0] w_p_d;

  assign w_en    = clken & ~reset_req;
  assign w_inr   = {1'b0, address} < LP_DEPTH;
  assign w_idx   = address[IDX_W-1:0];
  assign w_acc   = (r_state == S_READY) & w_en & ~reset
                 & chipselect & (read | write);
  assign w_wr    = w_acc & write;
  assign w_rd    = w_acc & read & ~write;
  assign w_sweep = (r_state == S_CLEAR) & w_en & ~reset;
  assign w_rdata = w_inr ? r_mem[w_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_busy  <= (CLEAR_ON_RESET != 0);
      r_cnt   <= '0;
    end else if (w_en && r_state == S_CLEAR) begin
      r_cnt <= r_cnt + IDX_W'(1);
      if (r_cnt == LAST) begin
        r_state <= S_READY;
        r_busy  <= 1'b0;
      end
    end
  end

  // Out-of-range writes are dropped; the index alias is never written.
  always_ff @(posedge clk) begin
    if (w_sweep) begin
      r_mem[r_cnt] <= CLEAR_VALUE;
    end else if (w_wr && w_inr) begin
      for (int b = 0; b < NB; b++)
        if (byteenable[b])
          r_mem[w_idx][b*8 +: 8] <= writedata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if ((w_wr | w_rd) & ~w_inr)
      r_err <= 1'b1;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              r_v1;
      logic [DATA_W-1:0] r_d1;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_v1 <= 1'b0;
          r_d1 <= '0;
        end else if (w_en) begin
          r_v1 <= w_rd;
          if (w_rd) r_d1 <= w_rdata;
        end
      end
      assign w_p_v = r_v1;
      assign w_p_d = r_d1;
    end else begin : g_lat1
      assign w_p_v = w_rd;
      assign w_p_d = w_rdata;
    end
  endgenerate

  // The last stage is only presented during an enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vq   <= 1'b0;
      r_dq   <= '0;
      r_hold <= '0;
    end else if (w_en) begin
      r_vq <= w_p_v;
      if (w_p_v) r_dq <= w_p_d;
      if (r_vq) r_hold <= r_dq;
    end
  end

  assign w_rdv         = r_vq & w_en;
  assign readdatavalid = w_rdv;
  assign readdata      = w_rdv ? r_dq : r_hold;
  assign busy          = r_busy;
  assign waitrequest   = r_busy | ~w_en;
  assign addr_err      = r_err;

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Randomised and directed bench for onchip_ram_pipelined.
// Reference: word array plus a queue of reads due at a given enabled-cycle count.
module tb_onchip_ram_pipelined;

  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_req = 1'b0;
  logic        clken = 1'b1;
  logic [7:0]  address = '0;
  logic [3:0]  byteenable = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        busy;
  logic        addr_err;

  onchip_ram_pipelined #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .READ_LATENCY(LAT),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rq_t;

  logic [31:0] mdl [DEPTH];
  rq_t         q [$];
  int          ecnt = 0;
  int          sweep_left = DEPTH;
  bit          m_err = 1'b0;
  logic [31:0] last_rd = '0;
  int          ncyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  obs_f, exp_f;
  logic [31:0] obs_d, exp_d;

  // One clock: drive, sample at negedge, advance the reference.
  task automatic cyc(input bit cs, input bit rd, input bit wr,
                     input bit ce, input bit rq, input bit rst,
                     input logic [7:0] a, input logic [3:0] be,
                     input logic [31:0] wd);
    bit  en;
    bit  ev;
    rq_t t;
    chipselect = cs; read = rd; write = wr;
    clken = ce; reset_req = rq; reset = rst;
    address = a; byteenable = be; writedata = wd;
    @(negedge clk);
    en = ce && !rq;
    ev = en && q.size() > 0 && q[0].due == ecnt;
    exp_f = {ev, (sweep_left > 0) || !en, sweep_left > 0, m_err};
    exp_d = ev ? q[0].d : last_rd;
    obs_f = {readdatavalid, waitrequest, busy, addr_err};
    obs_d = readdata;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
      sweep_left = DEPTH;
      last_rd = '0;
    end else if (en) begin
      if (ev) begin
        last_rd = q[0].d;
        void'(q.pop_front());
      end
      if (sweep_left > 0) begin
        mdl[DEPTH - sweep_left] = '0;
        sweep_left--;
      end else if (cs && wr) begin
        if (a < DEPTH) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mdl[a[3:0]][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          m_err = 1'b1;
        end
      end else if (cs && rd) begin
        t.due = ecnt + LAT;
        t.d = (a < DEPTH) ? mdl[a[3:0]] : 32'h0;
        q.push_back(t);
        if (a >= DEPTH) m_err = 1'b1;
      end
      ecnt++;
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 1, 0, 0, 8'd0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 1, 0, 1, 8'd0, 4'h0, 32'h0);
    cyc(0, 0, 0, 1, 0, 1, 8'd0, 4'h0, 32'h0);
    checks++;
    if (obs_f !== 4'b0110 || obs_d !== 32'h0) begin
      errors++;
      $display("FAIL reset_state vwbe=%b d=%h need 0110 0", obs_f, obs_d);
    end
  endtask

  task automatic test_sweep();
    int nb = 0;
    int nv = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      checks++;
      if (obs_f !== exp_f || obs_d !== exp_d) begin
        errors++;
        $display("FAIL sweep c%0d vwbe=%b d=%h need %b %h",
                 ncyc, obs_f, obs_d, exp_f, exp_d);
      end
      if (obs_f[1]) nb++;
    end
    checks++;
    if (nb != DEPTH) begin
      errors++;
      $display("FAIL sweep_len busy=%0d need %0d", nb, DEPTH);
    end
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (i < DEPTH) cyc(1, 1, 0, 1, 0, 0, 8'(i), 4'h0, 32'h0);
      else idle();
      checks++;
      if (obs_f !== exp_f || obs_d !== exp_d || (obs_f[3] && obs_d !== 0)) begin
        errors++;
        $display("FAIL clear_read c%0d vwbe=%b d=%h need %b %h",
                 ncyc, obs_f, obs_d, exp_f, exp_d);
      end
      if (obs_f[3]) nv++;
    end
    checks++;
    if (nv != DEPTH) begin
      errors++;
      $display("FAIL clear_count valids=%0d need %0d", nv, DEPTH);
    end
  endtask

  task automatic test_byte_write();
    int off = -1;
    logic [31:0] got = '0;
    cyc(1, 0, 1, 1, 0, 0, 8'd3, 4'b0101, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) cyc(1, 1, 0, 1, 0, 0, 8'd3, 4'h0, 32'h0);
      else idle();
      checks++;
      if (obs_f !== exp_f || obs_d !== exp_d) begin
        errors++;
        $display("FAIL byte_wr c%0d vwbe=%b d=%h need %b %h",
                 ncyc, obs_f, obs_d, exp_f, exp_d);
      end
      if (obs_f[3] && off < 0) begin
        off = i;
        got = obs_d;
      end
    end
    checks++;
    if (off != LAT || got !== 32'h00A500A5) begin
      errors++;
      $display("FAIL byte_lat off=%0d d=%h need %0d 00a500a5", off, got, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen [$];
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 1, 1, 0, 0, 8'(i), 4'hF, 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 11; i++) begin
      case (i)
        0, 1, 2: cyc(1, 1, 0, 1, 0, 0, 8'(i), 4'h0, 32'h0);
        3:       cyc(1, 1, 0, 0, 0, 0, 8'd3, 4'h0, 32'h0);
        4:       cyc(1, 1, 0, 1, 1, 0, 8'd3, 4'h0, 32'h0);
        5:       cyc(1, 1, 0, 1, 0, 0, 8'd3, 4'h0, 32'h0);
        default: idle();
      endcase
      checks++;
      if (obs_f !== exp_f || obs_d !== exp_d) begin
        errors++;
        $display("FAIL b2b c%0d vwbe=%b d=%h need %b %h",
                 ncyc, obs_f, obs_d, exp_f, exp_d);
      end
      if (obs_f[3]) seen.push_back(obs_d);
    end
    checks++;
    if (seen.size() != 4) begin
      errors++;
      $display("FAIL b2b_count valids=%0d need 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== 32'hC0DE_0000 + 32'(i)) begin
          errors++;
          $display("FAIL b2b_order idx%0d d=%h need %h",
                   i, seen[i], 32'hC0DE_0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:       cyc(1, 1, 0, 1, 0, 0, 8'd16, 4'h0, 32'h0);
        4:       cyc(1, 0, 1, 1, 0, 0, 8'd16, 4'hF, 32'hFFFF_FFFF);
        5:       cyc(1, 1, 0, 1, 0, 0, 8'd0, 4'h0, 32'h0);
        default: idle();
      endcase
      checks++;
      if (obs_f !== exp_f || obs_d !== exp_d) begin
        errors++;
        $display("FAIL oor c%0d vwbe=%b d=%h need %b %h",
                 ncyc, obs_f, obs_d, exp_f, exp_d);
      end
    end
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky addr_err=%b need 1", addr_err);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int nb = 0;
    int nv = 0;
    cyc(0, 0, 0, 1, 0, 1, 8'd0, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) idle();
    cyc(0, 0, 0, 1, 0, 1, 8'd0, 4'h0, 32'h0);
    for (int i = 0; i < 30; i++) begin
      idle();
      checks++;
      if (obs_f !== exp_f || obs_d !== exp_d) begin
        errors++;
        $display("FAIL resweep c%0d vwbe=%b d=%h need %b %h",
                 ncyc, obs_f, obs_d, exp_f, exp_d);
      end
      if (obs_f[2]) nb++;
    end
    checks++;
    if (nb != DEPTH) begin
      errors++;
      $display("FAIL resweep_len busy=%0d need %0d", nb, DEPTH);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 0) cyc(1, 1, 1, 1, 0, 0, 8'd5, 4'hF, 32'h5555_AAAA);
      else if (i == 4) cyc(1, 1, 0, 1, 0, 0, 8'd5, 4'h0, 32'h0);
      else idle();
      checks++;
      if (obs_f !== exp_f || obs_d !== exp_d) begin
        errors++;
        $display("FAIL rw_same c%0d vwbe=%b d=%h need %b %h",
                 ncyc, obs_f, obs_d, exp_f, exp_d);
      end
      if (obs_f[3]) begin
        nv++;
        checks++;
        if (i != 4 + LAT || obs_d !== 32'h5555_AAAA) begin
          errors++;
          $display("FAIL rw_data i%0d d=%h need 5555aaaa", i, obs_d);
        end
      end
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL rw_count valids=%0d need 1", nv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i < 590)
        cyc(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0,
            ($urandom % 5) != 0, ($urandom % 8) == 0, 1'b0,
            8'($urandom_range(0, 17)), 4'($urandom), $urandom);
      else
        idle();
      checks++;
      if (obs_f !== exp_f || obs_d !== exp_d) begin
        errors++;
        $display("FAIL random c%0d vwbe=%b d=%h need %b %h",
                 ncyc, obs_f, obs_d, exp_f, exp_d);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    test_reset();
    test_sweep();
    test_byte_write();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
